// File: rtl/flop_cmp_pkg.sv
// Shared types, constants and helpers for the flop equivalence sequencer.
// Imported by the sequencer top and its saturating-counter sub-module.
package flop_cmp_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_CLKHI  = 3'd3,
        S_CLKLO  = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6
    } seq_state_t;

    localparam int LOAD_TO_CHECK_CYC = 4;
    localparam int MAX_NCHK          = 256;

    // A vector fails unless each of its low n flags is exactly 1 (X/Z fails).
    function automatic logic is_fail(input logic [MAX_NCHK-1:0] ok, input int n);
        logic f;
        f = 1'b0;
        for (int i = 0; i < MAX_NCHK; i++) begin
            f = f | ((i < n) && (ok[i] !== 1'b1));
        end
        return f;
    endfunction

endpackage

// File: rtl/flop_cmp_satcnt.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module flop_cmp_satcnt
    import flop_cmp_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count register: clears, increments until all-ones, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != '1)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/flop_compare_sequencer.sv
// Sequences spec-vs-impl flop equivalence runs: stimulus request, settle,
// one DUT clock pulse, then a check of the per-check ok flags per vector.
module flop_compare_sequencer
    import flop_cmp_pkg::*;
#(
    parameter int NCHK   = 32,
    parameter int SETTLE = 1,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [CNTW-1:0] num_vectors,
    input  logic [NCHK-1:0] chk_ok,
    output logic            stim_req,
    output logic            dut_clk,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CNTW-1:0] vec_cnt,
    output logic [CNTW-1:0] fail_cnt,
    output logic [CNTW-1:0] first_fail_vec,
    output logic [NCHK-1:0] first_fail_mask,
    output logic            first_fail_vld
);

    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'((SETTLE > 0) ? (SETTLE - 1) : 0);

    seq_state_t      state_r, next_s;
    logic [SCW-1:0]  settle_cnt_r;
    logic [CNTW-1:0] num_lat_r, vec_cnt_r, first_fail_vec_r, fail_cnt_s;
    logic [NCHK-1:0] fail_mask_s, first_fail_mask_r;
    logic            first_fail_vld_r;
    logic            accept_s, check_upd_s, fail_s, fail_inc_s, last_vec_s, fail_zero_next_s;
    logic            stim_req_r, dut_clk_r, busy_r, done_r, pass_r;

    // Per-check failure mask; a flag that is not exactly 1 marks the check as failing.
    always_comb begin
        fail_mask_s = '0;
        for (int i = 0; i < NCHK; i++) begin
            fail_mask_s[i] = (chk_ok[i] !== 1'b1);
        end
    end

    assign fail_s           = is_fail(MAX_NCHK'(chk_ok), NCHK);
    assign accept_s         = start && !abort && ((state_r == S_IDLE) || (state_r == S_DONE));
    assign check_upd_s      = (state_r == S_CHECK) && !abort;
    assign fail_inc_s       = check_upd_s && fail_s;
    assign last_vec_s       = ((vec_cnt_r + CNTW'(1)) == num_lat_r);
    assign fail_zero_next_s = accept_s || ((fail_cnt_s == '0) && !fail_inc_s);

    // Next-state logic; abort overrides everything, including a same-cycle start.
    always_comb begin
        next_s = state_r;
        if (abort) begin
            next_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        next_s = (num_vectors == '0) ? S_DONE : S_LOAD;
                    end else begin
                        next_s = state_r;
                    end
                end
                S_LOAD:   next_s = (SETTLE == 0) ? S_CLKHI : S_SETTLE;
                S_SETTLE: begin
                    if (settle_cnt_r == '0) begin
                        next_s = S_CLKHI;
                    end else begin
                        next_s = S_SETTLE;
                    end
                end
                S_CLKHI:  next_s = S_CLKLO;
                S_CLKLO:  next_s = S_CHECK;
                S_CHECK:  next_s = last_vec_s ? S_DONE : S_LOAD;
                default:  next_s = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Settle down-counter, armed in LOAD and consumed in SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= '0;
        end else if (state_r == S_LOAD) begin
            settle_cnt_r <= SETTLE_LOAD;
        end else if ((state_r == S_SETTLE) && (settle_cnt_r != '0)) begin
            settle_cnt_r <= settle_cnt_r - SCW'(1);
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // Run bookkeeping: vector count, latched length and first-failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_lat_r         <= '0;
            vec_cnt_r         <= '0;
            first_fail_vec_r  <= '0;
            first_fail_mask_r <= '0;
            first_fail_vld_r  <= 1'b0;
        end else if (accept_s) begin
            num_lat_r         <= num_vectors;
            vec_cnt_r         <= '0;
            first_fail_vec_r  <= '0;
            first_fail_mask_r <= '0;
            first_fail_vld_r  <= 1'b0;
        end else if (check_upd_s) begin
            vec_cnt_r <= vec_cnt_r + CNTW'(1);
            if (fail_s && !first_fail_vld_r) begin
                first_fail_vec_r  <= vec_cnt_r;
                first_fail_mask_r <= fail_mask_s;
                first_fail_vld_r  <= 1'b1;
            end else begin
                first_fail_vec_r  <= first_fail_vec_r;
                first_fail_mask_r <= first_fail_mask_r;
                first_fail_vld_r  <= first_fail_vld_r;
            end
        end else begin
            vec_cnt_r <= vec_cnt_r;
        end
    end

    flop_cmp_satcnt #(.W(CNTW)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_s),
        .inc   (fail_inc_s),
        .cnt   (fail_cnt_s)
    );

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_req_r <= 1'b0;
            dut_clk_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
        end else begin
            stim_req_r <= (next_s == S_LOAD);
            dut_clk_r  <= (next_s == S_CLKHI);
            busy_r     <= (next_s == S_LOAD) || (next_s == S_SETTLE) || (next_s == S_CLKHI) ||
                          (next_s == S_CLKLO) || (next_s == S_CHECK);
            done_r     <= (next_s == S_DONE);
            pass_r     <= (next_s == S_DONE) && fail_zero_next_s;
        end
    end

    assign stim_req        = stim_req_r;
    assign dut_clk         = dut_clk_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign vec_cnt         = vec_cnt_r;
    assign fail_cnt        = fail_cnt_s;
    assign first_fail_vec  = first_fail_vec_r;
    assign first_fail_mask = first_fail_mask_r;
    assign first_fail_vld  = first_fail_vld_r;

endmodule

// File: tb/tb_flop_compare_sequencer.sv
// Directed bench for flop_compare_sequencer: a table of whole runs plus
// hand-written timing, abort, saturation and mid-run reset sequences.
module tb_flop_compare_sequencer;

    logic        clk, rst_n;
    logic        start, abort;
    logic [15:0] num_vectors;
    logic [31:0] chk_ok;
    logic        stim_req, dut_clk, busy, done, pass, first_fail_vld;
    logic [15:0] vec_cnt, fail_cnt, first_fail_vec;
    logic [31:0] first_fail_mask;

    logic       start4, abort4;
    logic [3:0] num4;
    logic [7:0] chk4;
    logic       stim4, dclk4, busy4, done4, pass4, ffvld4;
    logic [3:0] vec4, fail4, ffv4;
    logic [7:0] ffmask4;

    int n_chk, n_fail;

    flop_compare_sequencer #(.NCHK(32), .SETTLE(1), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_vectors(num_vectors), .chk_ok(chk_ok),
        .stim_req(stim_req), .dut_clk(dut_clk), .busy(busy), .done(done), .pass(pass),
        .vec_cnt(vec_cnt), .fail_cnt(fail_cnt), .first_fail_vec(first_fail_vec),
        .first_fail_mask(first_fail_mask), .first_fail_vld(first_fail_vld)
    );

    flop_compare_sequencer #(.NCHK(8), .SETTLE(0), .CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .num_vectors(num4), .chk_ok(chk4),
        .stim_req(stim4), .dut_clk(dclk4), .busy(busy4), .done(done4), .pass(pass4),
        .vec_cnt(vec4), .fail_cnt(fail4), .first_fail_vec(ffv4),
        .first_fail_mask(ffmask4), .first_fail_vld(ffvld4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] num;
        logic [15:0] flags;    // vectors that receive ok_bad instead of all-ones
        logic [31:0] ok_bad;
        logic [15:0] exp_vec;
        logic [15:0] exp_fail;
        logic [15:0] exp_ffv;
        logic [31:0] exp_mask;
        logic        exp_pass;
        logic        exp_vld;
    } rec_t;

    rec_t tbl[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_rec(input int idx, input rec_t r);
        int stim_seen, clk_seen;
        string p;
        p = $sformatf("rec%0d", idx);
        stim_seen = 0;
        clk_seen  = 0;
        num_vectors = r.num;
        chk_ok = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (stim_req) begin
                chk_ok = (stim_seen < 16 && r.flags[stim_seen]) ? r.ok_bad : 32'hFFFF_FFFF;
                stim_seen++;
            end
            if (dut_clk) clk_seen++;
            @(negedge clk);
        end
        chk({p, " done"},     64'(done),            64'(1'b1));
        chk({p, " vec_cnt"},  64'(vec_cnt),         64'(r.exp_vec));
        chk({p, " fail_cnt"}, 64'(fail_cnt),        64'(r.exp_fail));
        chk({p, " pass"},     64'(pass),            64'(r.exp_pass));
        chk({p, " ff_vld"},   64'(first_fail_vld),  64'(r.exp_vld));
        chk({p, " ff_vec"},   64'(first_fail_vec),  64'(r.exp_ffv));
        chk({p, " ff_mask"},  64'(first_fail_mask), 64'(r.exp_mask));
        chk({p, " stim_cnt"}, 64'(stim_seen),       64'(r.num));
        chk({p, " dclk_cnt"}, 64'(clk_seen),        64'(r.num));
    endtask

    initial begin
        logic [2:0] obs, exp3;
        int seen;

        n_chk = 0; n_fail = 0;
        start = 1'b0; abort = 1'b0; num_vectors = '0; chk_ok = '1;
        start4 = 1'b0; abort4 = 1'b0; num4 = '0; chk4 = '1;

        tbl[0] = '{16'd3, 16'h0000, 32'hFFFF_FFFF, 16'd3, 16'd0, 16'd0, 32'h0, 1'b1, 1'b0};
        tbl[1] = '{16'd5, 16'h0014, 32'hFFFF_FF7F, 16'd5, 16'd2, 16'd2, 32'h0000_0080, 1'b0, 1'b1};
        tbl[2] = '{16'd0, 16'h0000, 32'hFFFF_FFFF, 16'd0, 16'd0, 16'd0, 32'h0, 1'b1, 1'b0};
        tbl[3] = '{16'd4, 16'h000A, 32'h0FFF_FFFE, 16'd4, 16'd2, 16'd1, 32'hF000_0001, 1'b0, 1'b1};
        tbl[4] = '{16'd1, 16'h0001, {31'h7FFF_FFFF, 1'bx}, 16'd1, 16'd1, 16'd0, 32'h0000_0001, 1'b0, 1'b1};

        rst_n = 1'b0;
        #12;
        chk("reset outputs",
            64'({stim_req, dut_clk, busy, done, pass, first_fail_vld, vec_cnt, fail_cnt}), 64'd0);
        chk("reset ff_vec/mask", 64'({first_fail_vec, first_fail_mask}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_rec(i, tbl[i]);

        // Cycle-accurate waveform: SETTLE=1, three passing vectors, start in cycle 0.
        chk_ok = '1;
        num_vectors = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            obs  = {stim_req, dut_clk, done};
            exp3 = {(c == 1 || c == 6 || c == 11), (c == 3 || c == 8 || c == 13), (c >= 16)};
            chk($sformatf("timing cyc%0d {stim,dclk,done}", c), 64'(obs), 64'(exp3));
            @(negedge clk);
        end
        chk("timing pass", 64'({pass, vec_cnt, fail_cnt}), 64'({1'b1, 16'd3, 16'd0}));

        // Abort during the second CLKHI, with a simultaneous start.
        num_vectors = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            if (dut_clk) seen++;
            if (seen < 2) @(negedge clk);
        end
        chk("abort reached clkhi", 64'(seen), 64'd2);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort dclk/done/busy", 64'({dut_clk, done, busy}), 64'd0);
        chk("abort vec_cnt held", 64'(vec_cnt), 64'd1);
        @(negedge clk);
        chk("abort start ignored", 64'({busy, stim_req, done}), 64'd0);

        // Narrow instance: 15 vectors, all checks failing, SETTLE=0.
        chk4 = 8'h00;
        num4 = 4'd15;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int c = 0; c < 200 && !done4; c++) @(negedge clk);
        chk("sat done", 64'(done4), 64'd1);
        chk("sat fail_cnt", 64'(fail4), 64'd15);
        chk("sat vec_cnt", 64'(vec4), 64'd15);
        chk("sat pass/ffv/mask", 64'({pass4, ffvld4, ffv4, ffmask4}), 64'({1'b0, 1'b1, 4'd0, 8'hFF}));

        // Reset asserted while dut_clk is high must clear outputs before the next edge.
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !dclk4; c++) @(negedge clk);
        chk("midrun dclk high", 64'(dclk4), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun reset ctl", 64'({stim4, dclk4, busy4, done4, pass4, ffvld4}), 64'd0);
        chk("midrun reset cnt", 64'({vec4, fail4, ffv4, ffmask4}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
